sign_extender: RTL and testbench



---
 rtl/sign_extender.sv | 79 +++++++
 tb/tb_sign_extender.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sign_extender.sv
// SigmaCore RV32I immediate generator.
// Combinational immediate plus a registered copy toward execute.
package sigma_pkg;
    localparam logic [2:0] IMM_TYPE_NONE = 3'b000;
    localparam logic [2:0] IMM_TYPE_I    = 3'b001;
    localparam logic [2:0] IMM_TYPE_S    = 3'b010;
    localparam logic [2:0] IMM_TYPE_B    = 3'b011;
    localparam logic [2:0] IMM_TYPE_U    = 3'b100;
    localparam logic [2:0] IMM_TYPE_J    = 3'b101;
endpackage

module sign_extender
    import sigma_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] instruction_in,
    input  logic [2:0]      imm_type_in,
    input  logic            valid_in,
    output logic [XLEN-1:0] imm_extended_out,
    output logic            imm_type_err_out,
    output logic [XLEN-1:0] imm_q_out,
    output logic            imm_valid_q_out
);

    logic [XLEN-1:0] w_imm;
    logic            w_err;
    logic [XLEN-1:0] r_imm_q;
    logic            r_valid_q;
    logic [XLEN-1:0] w_i;

    assign w_i = instruction_in;

    // Select and extend the immediate field for the decoded format
    always_comb begin
        w_imm = '0;
        w_err = 1'b0;
        case (imm_type_in)
            IMM_TYPE_NONE: w_imm = '0;
            IMM_TYPE_I:
                w_imm = {{20{w_i[31]}}, w_i[31:20]};
            IMM_TYPE_S:
                w_imm = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
            IMM_TYPE_B:
                w_imm = {{19{w_i[31]}}, w_i[31], w_i[7],
                         w_i[30:25], w_i[11:8], 1'b0};
            IMM_TYPE_U:
                w_imm = {w_i[31:12], 12'h000};
            IMM_TYPE_J:
                w_imm = {{11{w_i[31]}}, w_i[31], w_i[19:12],
                         w_i[20], w_i[30:21], 1'b0};
            default: begin
                w_imm = '0;
                w_err = 1'b1;
            end
        endcase
    end

    // Pipeline copy: immediate captured only for valid instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_imm_q   <= '0;
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= valid_in;
            if (valid_in) begin
                r_imm_q <= w_imm;
            end
        end
    end

    assign imm_extended_out = w_imm;
    assign imm_type_err_out = w_err;
    assign imm_q_out        = r_imm_q;
    assign imm_valid_q_out  = r_valid_q;

endmodule

// File: tb/tb_sign_extender.sv
// Directed bench for the SigmaCore immediate generator.
// Hand-computed vectors for each format and the registered copy.
module tb_sign_extender;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction_in;
    logic [2:0]  imm_type_in;
    logic        valid_in;
    logic [31:0] imm_extended_out;
    logic        imm_type_err_out;
    logic [31:0] imm_q_out;
    logic        imm_valid_q_out;

    int errors;
    int checks;

    sign_extender #(.XLEN(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .instruction_in   (instruction_in),
        .imm_type_in      (imm_type_in),
        .valid_in         (valid_in),
        .imm_extended_out (imm_extended_out),
        .imm_type_err_out (imm_type_err_out),
        .imm_q_out        (imm_q_out),
        .imm_valid_q_out  (imm_valid_q_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n          = 1'b1;
        valid_in       = 1'b0;
        imm_type_in    = 3'b001;
        instruction_in = 32'h00500093;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imm_q_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_q: got %h want %h", imm_q_out, 32'h0);
        end
        checks++;
        if (imm_valid_q_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_vq: got %b want 0", imm_valid_q_out);
        end
        checks++;
        if (imm_extended_out !== 32'h5) begin
            errors++;
            $display("FAIL reset_comb: got %h want %h",
                     imm_extended_out, 32'h5);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_comb(input string nm, input logic [2:0] t,
                             input logic [31:0] ins,
                             input logic [31:0] exp,
                             input logic exp_err);
        imm_type_in    = t;
        instruction_in = ins;
        #1;
        checks++;
        if (imm_extended_out !== exp) begin
            errors++;
            $display("FAIL %s: ins %h got %h want %h",
                     nm, ins, imm_extended_out, exp);
        end
        checks++;
        if (imm_type_err_out !== exp_err) begin
            errors++;
            $display("FAIL %s_err: got %b want %b",
                     nm, imm_type_err_out, exp_err);
        end
    endtask

    task automatic test_none_and_err();
        test_comb("none", 3'b000, 32'hDEADBEEF, 32'h0, 1'b0);
        test_comb("t110", 3'b110, 32'hFFFFFFFF, 32'h0, 1'b1);
        test_comb("t111", 3'b111, 32'h12345678, 32'h0, 1'b1);
    endtask

    task automatic test_i_type();
        test_comb("i_pos", 3'b001, 32'h00500093, 32'h00000005, 1'b0);
        test_comb("i_neg", 3'b001, 32'hFFB00093, 32'hFFFFFFFB, 1'b0);
    endtask

    task automatic test_s_type();
        test_comb("s_pos", 3'b010, 32'h00002623, 32'h0000000C, 1'b0);
        test_comb("s_neg", 3'b010, 32'hFE002823, 32'hFFFFFFF0, 1'b0);
    endtask

    task automatic test_b_type();
        test_comb("b_pos", 3'b011, 32'h00A00A63, 32'h00000014, 1'b0);
        test_comb("b_neg", 3'b011, 32'hFE0006E3, 32'hFFFFFFEC, 1'b0);
    endtask

    task automatic test_u_type();
        test_comb("u_pos", 3'b100, 32'h123450B7, 32'h12345000, 1'b0);
        test_comb("u_neg", 3'b100, 32'hFEDCB0B7, 32'hFEDCB000, 1'b0);
    endtask

    task automatic test_j_type();
        test_comb("j_pos", 3'b101, 32'h3E80006F, 32'h000003E8, 1'b0);
        test_comb("j_neg", 3'b101, 32'hC19FF06F, 32'hFFFFFC18, 1'b0);
    endtask

    task automatic test_registered();
        @(negedge clk);
        valid_in       = 1'b1;
        imm_type_in    = 3'b001;
        instruction_in = 32'hFFB00093;
        @(posedge clk);
        #1;
        checks++;
        if (imm_q_out !== 32'hFFFFFFFB) begin
            errors++;
            $display("FAIL reg_load: got %h want %h",
                     imm_q_out, 32'hFFFFFFFB);
        end
        checks++;
        if (imm_valid_q_out !== 1'b1) begin
            errors++;
            $display("FAIL reg_vload: got %b want 1", imm_valid_q_out);
        end
        @(negedge clk);
        valid_in       = 1'b0;
        imm_type_in    = 3'b100;
        instruction_in = 32'h123450B7;
        @(posedge clk);
        #1;
        checks++;
        if (imm_q_out !== 32'hFFFFFFFB) begin
            errors++;
            $display("FAIL reg_hold: got %h want %h",
                     imm_q_out, 32'hFFFFFFFB);
        end
        checks++;
        if (imm_valid_q_out !== 1'b0) begin
            errors++;
            $display("FAIL reg_vhold: got %b want 0", imm_valid_q_out);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        valid_in       = 1'b1;
        imm_type_in    = 3'b010;
        instruction_in = 32'h00002623;
        @(posedge clk);
        #1;
        checks++;
        if (imm_q_out !== 32'h0000000C) begin
            errors++;
            $display("FAIL b2b_first: got %h want %h",
                     imm_q_out, 32'h0000000C);
        end
        imm_type_in    = 3'b101;
        instruction_in = 32'hC19FF06F;
        @(posedge clk);
        #1;
        checks++;
        if (imm_q_out !== 32'hFFFFFC18) begin
            errors++;
            $display("FAIL b2b_second: got %h want %h",
                     imm_q_out, 32'hFFFFFC18);
        end
        checks++;
        if (imm_valid_q_out !== 1'b1) begin
            errors++;
            $display("FAIL b2b_valid: got %b want 1", imm_valid_q_out);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imm_q_out !== 32'h0) begin
            errors++;
            $display("FAIL areset_q: got %h want %h", imm_q_out, 32'h0);
        end
        checks++;
        if (imm_valid_q_out !== 1'b0) begin
            errors++;
            $display("FAIL areset_vq: got %b want 0", imm_valid_q_out);
        end
        checks++;
        if (imm_extended_out !== 32'hFFFFFC18) begin
            errors++;
            $display("FAIL areset_comb: got %h want %h",
                     imm_extended_out, 32'hFFFFFC18);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (imm_q_out !== 32'hFFFFFC18) begin
            errors++;
            $display("FAIL arelease_q: got %h want %h",
                     imm_q_out, 32'hFFFFFC18);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_none_and_err();
        test_i_type();
        test_s_type();
        test_b_type();
        test_u_type();
        test_j_type();
        test_registered();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
